btn_debounce: RTL and testbench

Two-channel pushbutton conditioner that sits directly upstream of the LED up/down counter. It synchronises the raw east/west buttons and debounces each with a per-channel state machine. It emits one single-cycle pulse per qualified press, which the counter consumes as increment/decrement events, so the counter no longer needs its own hold counters. Optional auto-repeat is compiled in by macro.

---
 rtl/btn_debounce.sv | 194 +++++++++++++++++++
 tb/tb_btn_debounce.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - two-channel pushbutton synchroniser and debouncer with single-cycle press pulses
// Optional auto-repeat is compiled in when BTN_DEBOUNCE_AUTOREPEAT_EN is defined.

module btn_debounce_chan #(
    parameter int DEBOUNCE_CYCLES = 123456,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_btn,
    output logic o_pulse,
    output logic o_level
);
    localparam int MAX_A = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int MAX_C = (MAX_A > REPEAT_PERIOD) ? MAX_A : REPEAT_PERIOD;
    localparam int CW    = $clog2(MAX_C) + 1;
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESS_WAIT,
        ST_HELD,
        ST_RELEASE_WAIT
    } state_t;

    logic          r_sync1;
    logic          r_sync2;
    state_t        r_state;
    state_t        w_state_nx;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nx;
    logic          r_pulse;
    logic          w_pulse_nx;
    logic          r_level;
    logic          w_level_nx;
    logic          w_btn_s;

`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
    localparam logic [CW-1:0] RD_LAST = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] RP_LAST = CW'(REPEAT_PERIOD - 1);

    logic [CW-1:0] r_rcnt;
    logic [CW-1:0] w_rcnt_nx;
    logic          r_rpt_mode;
    logic          w_rpt_mode_nx;
`endif

    assign w_btn_s = r_sync2;
    assign o_pulse = r_pulse;
    assign o_level = r_level;

    // Two-flop synchroniser for the raw asynchronous button
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_pulse <= 1'b0;
            r_level <= 1'b0;
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
            r_rcnt     <= '0;
            r_rpt_mode <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_pulse <= w_pulse_nx;
            r_level <= w_level_nx;
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
            r_rcnt     <= w_rcnt_nx;
            r_rpt_mode <= w_rpt_mode_nx;
`endif
        end
    end

    // Debounce next-state logic; pulse only on a qualified press (and repeats when enabled)
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_pulse_nx = 1'b0;
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
        w_rcnt_nx     = r_rcnt;
        w_rpt_mode_nx = r_rpt_mode;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_btn_s) begin
                    w_state_nx = ST_PRESS_WAIT;
                    w_cnt_nx   = '0;
                end
            end
            ST_PRESS_WAIT: begin
                if (!w_btn_s) begin
                    w_state_nx = ST_IDLE;
                end else if (r_cnt == DB_LAST) begin
                    w_state_nx = ST_HELD;
                    w_pulse_nx = 1'b1;
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
                    w_rcnt_nx     = '0;
                    w_rpt_mode_nx = 1'b0;
`endif
                end else begin
                    w_cnt_nx = r_cnt + CNT_ONE;
                end
            end
            ST_HELD: begin
                if (!w_btn_s) begin
                    w_state_nx = ST_RELEASE_WAIT;
                    w_cnt_nx   = '0;
                end else begin
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
                    // First repeat after the initial delay, then at the shorter period
                    if (!r_rpt_mode && (r_rcnt == RD_LAST)) begin
                        w_pulse_nx    = 1'b1;
                        w_rcnt_nx     = '0;
                        w_rpt_mode_nx = 1'b1;
                    end else if (r_rpt_mode && (r_rcnt == RP_LAST)) begin
                        w_pulse_nx = 1'b1;
                        w_rcnt_nx  = '0;
                    end else begin
                        w_rcnt_nx = r_rcnt + CNT_ONE;
                    end
`endif
                end
            end
            ST_RELEASE_WAIT: begin
                // A bounce back high returns to HELD without a new pulse
                if (w_btn_s) begin
                    w_state_nx = ST_HELD;
                end else if (r_cnt == DB_LAST) begin
                    w_state_nx = ST_IDLE;
                end else begin
                    w_cnt_nx = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
                w_cnt_nx   = '0;
            end
        endcase
        w_level_nx = (w_state_nx == ST_HELD) || (w_state_nx == ST_RELEASE_WAIT);
    end
endmodule

module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 123456,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_east,
    input  logic btn_west,
    output logic east_pulse,
    output logic west_pulse,
    output logic east_level,
    output logic west_level
);
    btn_debounce_chan #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_east (
        .clk     (clk),
        .reset   (reset),
        .i_btn   (btn_east),
        .o_pulse (east_pulse),
        .o_level (east_level)
    );

    btn_debounce_chan #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_DELAY    (REPEAT_DELAY),
        .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_west (
        .clk     (clk),
        .reset   (reset),
        .i_btn   (btn_west),
        .o_pulse (west_pulse),
        .o_level (west_level)
    );
endmodule

// File: tb/tb_btn_debounce.sv
// tb/tb_btn_debounce.sv - self-checking bench for btn_debounce with a pulse-cycle scoreboard

module tb_btn_debounce;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic btn_east = 1'b0;
    logic btn_west = 1'b0;
    logic east_pulse;
    logic west_pulse;
    logic east_level;
    logic west_level;

    int cyc = 0;
    int n_vec = 0;
    int n_err = 0;
    int q_east[$];
    int q_west[$];
    int e_cyc;

    btn_debounce #(
        .DEBOUNCE_CYCLES (8),
        .REPEAT_DELAY    (20),
        .REPEAT_PERIOD   (5)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_east   (btn_east),
        .btn_west   (btn_west),
        .east_pulse (east_pulse),
        .west_pulse (west_pulse),
        .east_level (east_level),
        .west_level (west_level)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic step_chk_wlevel(input int n);
        repeat (n) begin
            @(negedge clk);
            chk("west_level_hold", west_level, 1);
        end
    endtask

    // Scoreboard: every pulse must match the next expected cycle; overdue entries are misses
    always @(negedge clk) begin
        while (q_east.size() > 0 && q_east[0] < cyc) begin
            chk("east_pulse_missed", cyc, q_east[0]);
            void'(q_east.pop_front());
        end
        while (q_west.size() > 0 && q_west[0] < cyc) begin
            chk("west_pulse_missed", cyc, q_west[0]);
            void'(q_west.pop_front());
        end
        if (east_pulse) begin
            if (q_east.size() > 0) chk("east_pulse_cycle", cyc, q_east.pop_front());
            else chk("east_pulse_unexpected", east_pulse, 0);
        end
        if (west_pulse) begin
            if (q_west.size() > 0) chk("west_pulse_cycle", cyc, q_west.pop_front());
            else chk("west_pulse_unexpected", west_pulse, 0);
        end
    end

    initial begin
        // 1. Reset behaviour
        step(3);
        chk("rst_east_pulse", east_pulse, 0);
        chk("rst_west_pulse", west_pulse, 0);
        chk("rst_east_level", east_level, 0);
        chk("rst_west_level", west_level, 0);
        reset = 1'b0;
        step(2);
        btn_east = 1'b1;
        e_cyc = cyc + 1;
        step(6);
        reset = 1'b1;
        step(1);
        chk("midrst_east_level", east_level, 0);
        chk("midrst_east_pulse", east_pulse, 0);
        step(2);
        reset = 1'b0;
        e_cyc = cyc + 1;
        q_east.push_back(e_cyc + 10);
        step(10);
        chk("postrst_level_early", east_level, 0);
        step(1);
        chk("postrst_level_set", east_level, 1);
        btn_east = 1'b0;
        step(15);
        chk("postrst_level_clear", east_level, 0);

        // 2. Clean 40-cycle east press
        btn_east = 1'b1;
        e_cyc = cyc + 1;
        q_east.push_back(e_cyc + 10);
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
        q_east.push_back(e_cyc + 30);
        q_east.push_back(e_cyc + 35);
        q_east.push_back(e_cyc + 40);
`endif
        step(10);
        chk("clean_level_early", east_level, 0);
        step(1);
        chk("clean_level_set", east_level, 1);
        step(29);
        btn_east = 1'b0;
        step(10);
        chk("clean_level_release_hold", east_level, 1);
        step(1);
        chk("clean_level_release", east_level, 0);
        chk("clean_west_level", west_level, 0);

        // 3. West bounce: short toggles, then a hold with short low bounces
        for (int i = 0; i < 5; i++) begin
            btn_west = 1'b1;
            step(3);
            btn_west = 1'b0;
            step(3);
        end
        step(15);
        chk("bounce_west_level_idle", west_level, 0);
        btn_west = 1'b1;
        e_cyc = cyc + 1;
        q_west.push_back(e_cyc + 10);
        step(14);
        chk("bounce_west_level_set", west_level, 1);
        btn_west = 1'b0;
        step_chk_wlevel(5);
        btn_west = 1'b1;
        step_chk_wlevel(4);
        btn_west = 1'b0;
        step_chk_wlevel(5);
        btn_west = 1'b1;
        step_chk_wlevel(3);
        btn_west = 1'b0;
        step_chk_wlevel(10);
        step(1);
        chk("bounce_west_level_release", west_level, 0);

        // 4. Glitch threshold: 8 cycles rejected, 9 cycles accepted
        btn_east = 1'b1;
        step(8);
        btn_east = 1'b0;
        step(20);
        chk("glitch8_level", east_level, 0);
        btn_east = 1'b1;
        e_cyc = cyc + 1;
        q_east.push_back(e_cyc + 10);
        step(9);
        btn_east = 1'b0;
        step(20);
        chk("glitch9_level_after", east_level, 0);

        // 5. Simultaneous presses
        btn_east = 1'b1;
        btn_west = 1'b1;
        e_cyc = cyc + 1;
        q_east.push_back(e_cyc + 10);
        q_west.push_back(e_cyc + 10);
        step(11);
        chk("simul_east_level", east_level, 1);
        chk("simul_west_level", west_level, 1);
        step(4);
        btn_east = 1'b0;
        btn_west = 1'b0;
        step(15);

        // 6. Long east hold: auto-repeat pulses when enabled, single pulse otherwise
        btn_east = 1'b1;
        e_cyc = cyc + 1;
        q_east.push_back(e_cyc + 10);
`ifdef BTN_DEBOUNCE_AUTOREPEAT_EN
        for (int k = 20; k <= 45; k += 5) q_east.push_back(e_cyc + 10 + k);
`endif
        step(57);
        btn_east = 1'b0;
        step(20);
        chk("repeat_level_after", east_level, 0);

        chk("east_queue_empty", q_east.size(), 0);
        chk("west_queue_empty", q_west.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
